// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard front end: decoder state,
// set-2 prefix codes, HID keycodes and the scancode -> HID lookup.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    DEC_BASE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_e;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;

  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_RIGHT = 8'h4F;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_DOWN  = 8'h51;
  localparam logic [7:0] HID_UP    = 8'h52;

  typedef struct packed {
    logic       hit;
    logic [7:0] hid;
  } kc_lookup_t;

  function automatic kc_lookup_t kc_lookup(input logic ext, input logic [7:0] sc);
    kc_lookup_t r;
    r.hit = 1'b1;
    r.hid = 8'h00;
    if (ext) begin
      unique case (sc)
        8'h6B:   r.hid = HID_LEFT;
        8'h74:   r.hid = HID_RIGHT;
        8'h75:   r.hid = HID_UP;
        8'h72:   r.hid = HID_DOWN;
        default: r.hit = 1'b0;
      endcase
    end else begin
      unique case (sc)
        8'h1C:   r.hid = HID_A;
        8'h23:   r.hid = HID_D;
        8'h1B:   r.hid = HID_S;
        8'h1D:   r.hid = HID_W;
        8'h29:   r.hid = HID_SPACE;
        default: r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame
// FSM with odd-parity/stop checking and a mid-frame inactivity timeout.
module ps2_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  rx_state_e      state_q, state_d;
  logic [1:0]     clk_sync_q, dat_sync_q;
  logic           clk_prev_q;
  logic [2:0]     cnt_q, cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [7:0]     rx_byte_q, rx_byte_d;
  logic           rx_valid_q, rx_valid_d;
  logic           frame_err_q, frame_err_d;

  logic fall, bit_in;
  assign fall   = clk_prev_q & ~clk_sync_q[1];
  assign bit_in = dat_sync_q[1];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_sync_q  <= '0;
      dat_sync_q  <= '0;
      clk_prev_q  <= 1'b0;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      dat_sync_q  <= {dat_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    tmo_d       = (fall || state_q == RX_IDLE) ? '0 : tmo_q + TW'(1);
    if (fall) begin
      unique case (state_q)
        RX_IDLE: if (!bit_in) begin
          state_d = RX_DATA;
          cnt_d   = '0;
        end
        RX_DATA: begin
          shift_d = {bit_in, shift_q[7:1]};  // LSB arrives first
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = bit_in;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          if (bit_in && (^{shift_q, par_q})) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE && tmo_q == TW'(TIMEOUT_CYCLES)) begin
      state_d     = RX_IDLE;
      frame_err_d = 1'b1;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 set-2 make/break decoder producing a level-held HID keycode
// (latest mapped press wins; a break clears only the key currently held).
module ps2_keycode_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_event,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte_w;
  logic       rx_valid_w;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .Clk       (Clk),
    .Reset     (Reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte_w),
    .rx_valid  (rx_valid_w),
    .frame_err (frame_err)
  );

  dec_state_e dstate_q, dstate_d;
  logic [7:0] kc_q, kc_d;
  logic       kev_q, kev_d;
  logic       do_lookup, is_ext, is_break;
  kc_lookup_t lk;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dstate_q <= DEC_BASE;
      kc_q     <= '0;
      kev_q    <= 1'b0;
    end else begin
      dstate_q <= dstate_d;
      kc_q     <= kc_d;
      kev_q    <= kev_d;
    end
  end

  always_comb begin
    dstate_d  = dstate_q;
    kc_d      = kc_q;
    do_lookup = 1'b0;
    is_ext    = 1'b0;
    is_break  = 1'b0;
    if (rx_valid_w) begin
      unique case (dstate_q)
        DEC_BASE:
          if (rx_byte_w == SC_E0)      dstate_d = DEC_EXT;
          else if (rx_byte_w == SC_F0) dstate_d = DEC_BRK;
          else                         do_lookup = 1'b1;
        DEC_EXT:
          if (rx_byte_w == SC_F0)      dstate_d = DEC_EXT_BRK;
          else if (rx_byte_w != SC_E0) begin
            do_lookup = 1'b1;
            is_ext    = 1'b1;
          end
        DEC_BRK:
          if (rx_byte_w != SC_F0) begin
            do_lookup = 1'b1;
            is_break  = 1'b1;
          end
        DEC_EXT_BRK: begin
          do_lookup = 1'b1;
          is_ext    = 1'b1;
          is_break  = 1'b1;
        end
        default: dstate_d = DEC_BASE;
      endcase
    end
    lk = kc_lookup(is_ext, rx_byte_w);
    if (do_lookup) begin
      dstate_d = DEC_BASE;
      // A break of a key other than the held one is stale and ignored
      if (lk.hit) begin
        if (!is_break)           kc_d = lk.hid;
        else if (lk.hid == kc_q) kc_d = '0;
      end
    end
    kev_d = (kc_d != kc_q);
  end

  assign keycode   = kc_q;
  assign key_event = kev_q;
  assign rx_byte   = rx_byte_w;
  assign rx_valid  = rx_valid_w;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Randomized scoreboard bench: a byte-level keyboard model predicts rx bytes,
// frame errors and keycode changes; a negedge monitor checks DUT outputs.
module tb_ps2_keycode_decoder;

  localparam int TMO = 300;

  logic       Clk = 1'b0;
  logic       Reset, ps2_clk, ps2_data;
  logic [7:0] keycode, rx_byte;
  logic       key_event, rx_valid, frame_err;

  ps2_keycode_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .key_event (key_event),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_kc_q[$];
  int         exp_err_n = 0;

  // reference model state
  logic [7:0] base_map[logic [7:0]];
  logic [7:0] ext_map[logic [7:0]];
  logic       ext_f = 1'b0, brk_f = 1'b0;
  logic [7:0] kc_m = 8'h00;

  // monitor
  int         last_rxv = -10;
  logic [7:0] kc_prev = 8'h00;
  always @(negedge Clk) begin : mon
    logic [7:0] e;
    if (!Reset) begin
      if (key_event) begin
        tests++;
        if (exp_kc_q.size() == 0) begin
          fails++; $display("FAIL key_event unexpected: keycode=%h, none expected", keycode);
        end else begin
          e = exp_kc_q.pop_front();
          if (keycode !== e) begin
            fails++; $display("FAIL keycode: got %h expected %h", keycode, e);
          end
        end
        tests++;
        if (cyc != last_rxv + 1) begin
          fails++; $display("FAIL key_event latency: at cycle %0d, rx_valid at %0d", cyc, last_rxv);
        end
      end else if (keycode !== kc_prev) begin
        tests++; fails++;
        $display("FAIL keycode changed without key_event: %h -> %h", kc_prev, keycode);
      end
      if (rx_valid) begin
        last_rxv = cyc;
        tests++;
        if (exp_rx_q.size() == 0) begin
          fails++; $display("FAIL rx_valid unexpected: rx_byte=%h", rx_byte);
        end else begin
          e = exp_rx_q.pop_front();
          if (rx_byte !== e) begin
            fails++; $display("FAIL rx_byte: got %h expected %h", rx_byte, e);
          end
        end
      end
      if (frame_err) begin
        tests++;
        if (exp_err_n == 0) begin
          fails++; $display("FAIL frame_err unexpected: got 1 expected 0");
        end else exp_err_n--;
      end
    end
    kc_prev = keycode;
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++; $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // byte-level behaviour of the keyboard protocol
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] nk;
    logic       hit;
    logic [7:0] hid;
    exp_rx_q.push_back(b);
    if (b == 8'hE0 && !brk_f) ext_f = 1'b1;
    else if (b == 8'hF0 && !(brk_f && ext_f)) brk_f = 1'b1;
    else begin
      nk  = kc_m;
      hit = ext_f ? ext_map.exists(b) : base_map.exists(b);
      hid = 8'h00;
      if (hit) hid = ext_f ? ext_map[b] : base_map[b];
      if (hit && !brk_f) nk = hid;
      else if (hit && brk_f && hid == kc_m) nk = 8'h00;
      ext_f = 1'b0;
      brk_f = 1'b0;
      if (nk != kc_m) begin
        exp_kc_q.push_back(nk);
        kc_m = nk;
      end
    end
  endtask

  task automatic drive_bit(input logic v);
    ps2_data = v;
    wait_cyc(4);
    ps2_clk = 1'b0;
    wait_cyc(8);
    ps2_clk = 1'b1;
    wait_cyc(4);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic par;
    if (!bad_par && !bad_stop) model_byte(b);
    else exp_err_n++;
    par = ~(^b) ^ bad_par;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    drive_bit(~bad_stop);
    ps2_data = 1'b1;
    wait_cyc(20);
  endtask

  task automatic send_partial_timeout();
    exp_err_n++;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    wait_cyc(TMO + 100);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_rx_q.size() != 0 || exp_kc_q.size() != 0 || exp_err_n != 0) && n < 200) begin
      wait_cyc(1);
      n++;
    end
    tests++;
    if (exp_rx_q.size() != 0 || exp_kc_q.size() != 0 || exp_err_n != 0) begin
      fails++;
      $display("FAIL %s drain: pending rx=%0d kc=%0d err=%0d, expected 0", name,
               exp_rx_q.size(), exp_kc_q.size(), exp_err_n);
      exp_rx_q.delete(); exp_kc_q.delete(); exp_err_n = 0;
    end
  endtask

  logic [7:0] pool[16] = '{8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h29, 8'h6B, 8'h74, 8'h75,
                          8'h72, 8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE};

  initial begin
    base_map[8'h1C] = 8'h04; base_map[8'h23] = 8'h07; base_map[8'h1B] = 8'h16;
    base_map[8'h1D] = 8'h1A; base_map[8'h29] = 8'h2C;
    ext_map[8'h6B] = 8'h50; ext_map[8'h74] = 8'h4F;
    ext_map[8'h75] = 8'h52; ext_map[8'h72] = 8'h51;

    Reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(5);
    check8("reset keycode", keycode, 8'h00);
    check8("reset rx_byte", rx_byte, 8'h00);
    check8("reset pulses", {5'd0, key_event, rx_valid, frame_err}, 8'h00);
    Reset = 1'b0;
    wait_cyc(10);

    send_frame(8'h1C, 0, 0); drain("make A");
    check8("A held", keycode, 8'h04);
    send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0); drain("break A");
    check8("A released", keycode, 8'h00);

    send_frame(8'h1C, 0, 0); send_frame(8'h23, 0, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0); drain("stale break");
    check8("stale break keeps D", keycode, 8'h07);
    send_frame(8'h23, 0, 0); drain("typematic");
    check8("typematic D", keycode, 8'h07);
    send_frame(8'hF0, 0, 0); send_frame(8'h23, 0, 0); drain("break D");
    check8("D released", keycode, 8'h00);

    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0); drain("make up");
    check8("up held", keycode, 8'h52);
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    drain("break up");
    check8("up released", keycode, 8'h00);
    send_frame(8'h75, 0, 0); drain("base after ext break");
    check8("75 unmapped in base", keycode, 8'h00);

    send_frame(8'h1D, 1, 0); drain("bad parity");
    check8("bad parity keycode", keycode, 8'h00);
    send_partial_timeout(); drain("timeout");
    send_frame(8'h1D, 0, 0); drain("make W");
    check8("W held", keycode, 8'h1A);
    send_frame(8'h29, 0, 1); drain("bad stop");

    // reset mid-frame after a make
    send_frame(8'h1C, 0, 0); drain("make A pre-reset");
    drive_bit(1'b0); drive_bit(1'b1);
    ps2_data = 1'b0; ps2_clk = 1'b0;
    wait_cyc(3);
    Reset = 1'b1;
    wait_cyc(2);
    check8("mid-reset keycode", keycode, 8'h00);
    check8("mid-reset pulses", {5'd0, key_event, rx_valid, frame_err}, 8'h00);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    kc_m = 8'h00; ext_f = 1'b0; brk_f = 1'b0;
    wait_cyc(5);
    Reset = 1'b0;
    wait_cyc(10);
    send_frame(8'h23, 0, 0); drain("post-reset D");
    check8("post-reset D", keycode, 8'h07);

    for (int i = 0; i < 120; i++) begin
      logic [7:0] b;
      int r;
      r = int'($urandom_range(0, 19));
      b = (r < 16) ? pool[r] : 8'($urandom);
      r = int'($urandom_range(0, 39));
      if (r == 0)      send_partial_timeout();
      else if (r < 3)  send_frame(b, 1, 0);
      else if (r < 5)  send_frame(b, 0, 1);
      else             send_frame(b, 0, 0);
    end
    drain("random");
    check8("random final keycode", keycode, kc_m);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
